pe_mult_sched: RTL and testbench
================================

// Module: pe_mult_sched
// PURPOSE
//  Shares the single 32-lane int16 multiplier array (pe_mult) between NREQ operand requesters in the matrix PE.
//  Round-robin arbitration picks one requester per cycle and registers its 512b neuron/weight vectors.
//  The registered operands drive pe_mult; the 1024b product vector is returned on a valid/ready
//  result port, tagged with the winning requester id. Fully pipelined, 1 op/cycle peak.
// PARAMETERS
//  NREQ   2   number of requesters, 2..8
//  IDW    1   width of res_id, = clog2(NREQ), min 1
// PORTS
//  clk          in   1          single clock, all logic rising-edge
//  rst_n        in   1          synchronous, active-low reset
//  clr          in   1          sync flush of in-flight ops; rr pointer kept
//  req_valid    in   NREQ       requester i has operands
//  req_ready    out  NREQ       one-hot grant, transfer when valid&ready
//  req_neuron   in   NREQ*512   requester i neuron vector at [512*i+:512]
//  req_weight   in   NREQ*512   requester i weight vector at [512*i+:512]
//  res_valid    out  1          result vector valid
//  res_ready    in   1          consumer accepts result
//  res_data     out  1024       32 x signed 32b products, lane k at [32k+:32]
//  res_id       out  IDW        requester index that produced res_data
//  busy         out  1          any pipeline stage holds a valid op
// BEHAVIOUR
//  Pipeline: S1 = operand register (s1_valid, s1_id, s1_neuron, s1_weight);
//            S2 = result register (res_valid, res_id, res_data = pe_mult(s1 operands)).
//  s2_free  = !res_valid | res_ready;  s1_adv = s1_valid & s2_free;  s1_free = !s1_valid | s1_adv.
//  Grant only when s1_free: search req_valid starting at rr_ptr, wrapping mod NREQ; first set bit wins.
//  req_ready = one-hot grant; combinational from req_valid, rr_ptr and pipeline state. req_ready
//   is all-zero when s1_free=0 or no request is pending.
//  On a grant to i: S1 loads requester i's vectors, s1_id=i, and rr_ptr <= (i+1) mod NREQ. rr_ptr is unchanged without a grant.
//  Latency: accept in cycle t -> res_valid=1 in cycle t+2 when there is no backpressure. Throughput 1/cycle.
//  Backpressure: while res_valid & !res_ready, res_data/res_id hold stable. S1 holds if full. No grants while S1 is full and stalled.
//  Arithmetic: each lane is signed16 x signed16 -> signed32, exact, no saturation.
//   Lane k uses bits [16k+:16] of both operands.
//  Simultaneous: S2 consume, S1->S2 advance and a new grant all occur in the same cycle (no bubble).
//  clr=1: s1_valid<=0, res_valid<=0, req_ready=0 that cycle. In-flight ops are dropped; rr_ptr is retained.
//  Reset (rst_n=0 at a clock edge), including mid-operation:
//   rr_ptr=0, s1_valid=0, res_valid=0, res_id=0, res_data=0, busy=0.
//   req_ready=0 while rst_n=0. In-flight ops are discarded.
//  busy = s1_valid | res_valid.
//  Priority of events: reset > clr > normal operation.
// STRUCTURE
//  Shared package pe_pkg: PE_LANES=32, PE_IN_W=16, PE_OUT_W=32, PE_VEC_IN_W=512, PE_VEC_OUT_W=1024.
//  Sub-module pe_rr_arbiter #(NREQ): inputs req, ptr, en; outputs onehot gnt and gnt_idx. Pure combinational.
//  rr_ptr register and both pipeline registers live in pe_mult_sched. pe_mult is instantiated as-is between S1 and S2.
// TESTING
//  1. NREQ=2; req0 only, lane0 neuron=3, weight=-4, res_ready=1 -> res_valid at t+2, lane0=0xFFFFFFF4, res_id=0.
//  2. Both requesters held valid for 4 cycles, res_ready=1 -> grants 0,1,0,1; res_id sequence 0,1,0,1; no bubbles.
//  3. Full-scale operands: lane31 0x8000*0x8000 -> 0x40000000; 0x7FFF*0x8000 -> 0xC0008000.
//  4. res_ready=0 for 5 cycles with a stream on req0 -> two ops stored, then req_ready=0; res_data stable.
//     Release -> all ops delivered in order, no loss and no duplicates.
//  5. clr, then rst_n=0 mid-stream -> next cycle busy=0, res_valid=0, req_ready=0.
//     After reset the first grant goes to requester 0.

Source files
------------

// File: rtl/pe_pkg.sv
// Shared datapath constants for the matrix PE multiplier array and its scheduler.
package pe_pkg;
    localparam int PE_LANES     = 32;
    localparam int PE_IN_W      = 16;
    localparam int PE_OUT_W     = 32;
    localparam int PE_VEC_IN_W  = PE_LANES * PE_IN_W;
    localparam int PE_VEC_OUT_W = PE_LANES * PE_OUT_W;
endpackage

// File: rtl/pe_mult_sched_if.sv
// Operand request / product result bundle between NREQ requesters and the multiplier scheduler.
interface pe_mult_sched_if
    import pe_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int IDW  = 1
);
    logic [NREQ-1:0]             req_valid;
    logic [NREQ-1:0]             req_ready;
    logic [NREQ*PE_VEC_IN_W-1:0] req_neuron;
    logic [NREQ*PE_VEC_IN_W-1:0] req_weight;
    logic                        res_valid;
    logic                        res_ready;
    logic [PE_VEC_OUT_W-1:0]     res_data;
    logic [IDW-1:0]              res_id;

    modport master (
        output req_valid, req_neuron, req_weight, res_ready,
        input  req_ready, res_valid, res_data, res_id
    );

    modport slave (
        input  req_valid, req_neuron, req_weight, res_ready,
        output req_ready, res_valid, res_data, res_id
    );
endinterface

// File: rtl/pe_mult.sv
// 32-lane signed int16 x int16 -> int32 multiplier array, purely combinational.
module pe_mult
    import pe_pkg::*;
(
    input  logic [PE_VEC_IN_W-1:0]  i_neuron,
    input  logic [PE_VEC_IN_W-1:0]  i_weight,
    output logic [PE_VEC_OUT_W-1:0] o_prod
);
    for (genvar k = 0; k < PE_LANES; k++) begin : g_lane
        logic signed [PE_IN_W-1:0]  w_a;
        logic signed [PE_IN_W-1:0]  w_b;
        logic signed [PE_OUT_W-1:0] w_p;

        assign w_a = i_neuron[PE_IN_W*k +: PE_IN_W];
        assign w_b = i_weight[PE_IN_W*k +: PE_IN_W];
        // Sign-extend before multiplying so the full 32b product is exact.
        assign w_p = PE_OUT_W'(w_a) * PE_OUT_W'(w_b);
        assign o_prod[PE_OUT_W*k +: PE_OUT_W] = w_p;
    end
endmodule

// File: rtl/pe_rr_arbiter.sv
// Round-robin one-hot arbiter: first asserted request at or after ptr, wrapping mod NREQ.
module pe_rr_arbiter #(
    parameter int NREQ = 2,
    parameter int IDW  = 1
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [IDW-1:0]  i_ptr,
    input  logic            i_en,
    output logic [NREQ-1:0] o_gnt,
    output logic [IDW-1:0]  o_gnt_idx
);
    always_comb begin
        int   v_idx;
        logic v_found;
        // NOTE: every output gets a default before the search loop, so no path leaves a latch.
        o_gnt     = '0;
        o_gnt_idx = '0;
        v_found   = 1'b0;
        v_idx     = 0;
        for (int k = 0; k < NREQ; k++) begin
            v_idx = (int'(i_ptr) + k) % NREQ;
            if (i_en && !v_found && i_req[v_idx]) begin
                o_gnt[v_idx] = 1'b1;
                o_gnt_idx    = v_idx[IDW-1:0];
                v_found      = 1'b1;
            end
        end
    end
endmodule

// File: rtl/pe_mult_sched.sv
// Two-stage scheduler sharing one pe_mult array among NREQ requesters with round-robin grants.
module pe_mult_sched
    import pe_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    pe_mult_sched_if.slave   bus,
    output logic             busy
);
    logic [IDW-1:0]          r_rr_ptr;
    logic                    r_s1_valid;
    logic [IDW-1:0]          r_s1_id;
    logic [PE_VEC_IN_W-1:0]  r_s1_neuron;
    logic [PE_VEC_IN_W-1:0]  r_s1_weight;
    logic                    r_res_valid;
    logic [IDW-1:0]          r_res_id;
    logic [PE_VEC_OUT_W-1:0] r_res_data;

    logic                    w_s2_free;
    logic                    w_s1_adv;
    logic                    w_s1_free;
    logic                    w_arb_en;
    logic [NREQ-1:0]         w_gnt;
    logic [IDW-1:0]          w_gnt_idx;
    logic                    w_grant;
    logic [PE_VEC_OUT_W-1:0] w_prod;

    assign w_s2_free = !r_res_valid || bus.res_ready;
    assign w_s1_adv  = r_s1_valid && w_s2_free;
    assign w_s1_free = !r_s1_valid || w_s1_adv;
    // Reset and flush both suppress grants in the same cycle they are asserted.
    assign w_arb_en  = w_s1_free && !clr && rst_n;
    assign w_grant   = |w_gnt;

    pe_rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
        .i_req     (bus.req_valid),
        .i_ptr     (r_rr_ptr),
        .i_en      (w_arb_en),
        .o_gnt     (w_gnt),
        .o_gnt_idx (w_gnt_idx)
    );

    pe_mult u_mult (
        .i_neuron (r_s1_neuron),
        .i_weight (r_s1_weight),
        .o_prod   (w_prod)
    );

    // NOTE: state registers use non-blocking assignments so every stage samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rr_ptr    <= '0;
            r_s1_valid  <= 1'b0;
            r_s1_id     <= '0;
            r_s1_neuron <= '0;
            r_s1_weight <= '0;
            r_res_valid <= 1'b0;
            r_res_id    <= '0;
            r_res_data  <= '0;
        end else if (clr) begin
            r_s1_valid  <= 1'b0;
            r_res_valid <= 1'b0;
        end else begin
            if (w_grant) begin
                r_s1_valid  <= 1'b1;
                r_s1_id     <= w_gnt_idx;
                r_s1_neuron <= bus.req_neuron[PE_VEC_IN_W*w_gnt_idx +: PE_VEC_IN_W];
                r_s1_weight <= bus.req_weight[PE_VEC_IN_W*w_gnt_idx +: PE_VEC_IN_W];
                r_rr_ptr    <= (int'(w_gnt_idx) == NREQ - 1) ? '0 : w_gnt_idx + 1'b1;
            end else if (w_s1_adv) begin
                r_s1_valid  <= 1'b0;
            end

            if (w_s2_free) begin
                r_res_valid <= r_s1_valid;
                if (r_s1_valid) begin
                    r_res_id   <= r_s1_id;
                    r_res_data <= w_prod;
                end
            end
        end
    end

    assign bus.req_ready = w_gnt;
    assign bus.res_valid = r_res_valid;
    assign bus.res_id    = r_res_id;
    assign bus.res_data  = r_res_data;
    assign busy          = r_s1_valid || r_res_valid;
endmodule

// File: tb/tb_pe_mult_sched.sv
// Directed bench for pe_mult_sched with NREQ=2: latency, round-robin, full-scale math, stall, clr, reset.
module tb_pe_mult_sched;
    import pe_pkg::*;

    localparam int NREQ = 2;
    localparam int IDW  = 1;

    logic clk;
    logic rst_n;
    logic clr;
    logic busy;

    logic [PE_VEC_IN_W-1:0] n0, w0, n1, w1;

    int n_cmp;
    int n_err;

    pe_mult_sched_if #(.NREQ(NREQ), .IDW(IDW)) bus ();

    assign bus.req_neuron = {n1, n0};
    assign bus.req_weight = {w1, w0};

    pe_mult_sched #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .bus   (bus.slave),
        .busy  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [PE_VEC_OUT_W-1:0] obs,
                         input logic [PE_VEC_OUT_W-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [PE_VEC_IN_W-1:0] vi(input int lane, input logic [PE_IN_W-1:0] v);
        vi = '0;
        vi[PE_IN_W*lane +: PE_IN_W] = v;
    endfunction

    function automatic logic [PE_VEC_OUT_W-1:0] pv(input int lane, input logic [PE_OUT_W-1:0] v);
        pv = '0;
        pv[PE_OUT_W*lane +: PE_OUT_W] = v;
    endfunction

    logic [PE_VEC_OUT_W-1:0] exp_a, exp_b;

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        clr   = 1'b0;
        n0 = '0; w0 = '0; n1 = '0; w1 = '0;
        bus.req_valid = 2'b11;
        bus.res_ready = 1'b1;

        // Reset state, with requests pending
        tick();
        tick();
        #1;
        check("rst_busy",      busy,          1'b0);
        check("rst_res_valid", bus.res_valid, 1'b0);
        check("rst_req_ready", bus.req_ready, 2'b00);
        check("rst_res_data",  bus.res_data,  '0);

        // 1: single op on req0, lane0 3 * -4
        rst_n = 1'b1;
        bus.req_valid = 2'b01;
        n0 = vi(0, 16'd3);
        w0 = vi(0, 16'hFFFC);
        #1;
        check("t1_gnt", bus.req_ready, 2'b01);
        tick();
        bus.req_valid = 2'b00;
        #1;
        check("t1_rv_t1",   bus.res_valid, 1'b0);
        check("t1_busy_t1", busy,          1'b1);
        tick();
        #1;
        check("t1_rv_t2", bus.res_valid, 1'b1);
        check("t1_data",  bus.res_data,  pv(0, 32'hFFFF_FFF4));
        check("t1_id",    bus.res_id,    1'b0);
        tick();
        #1;
        check("t1_rv_end",   bus.res_valid, 1'b0);
        check("t1_busy_end", busy,          1'b0);

        // 3: full-scale operands on req1 (pointer is at 1 after test 1)
        n1 = vi(31, 16'h8000) | vi(30, 16'h7FFF);
        w1 = vi(31, 16'h8000) | vi(30, 16'h8000);
        bus.req_valid = 2'b10;
        #1;
        check("t3_gnt", bus.req_ready, 2'b10);
        tick();
        bus.req_valid = 2'b00;
        tick();
        #1;
        check("t3_rv",   bus.res_valid, 1'b1);
        check("t3_data", bus.res_data,  pv(31, 32'h4000_0000) | pv(30, 32'hC000_8000));
        check("t3_id",   bus.res_id,    1'b1);
        tick();

        // 2: both requesters for 4 cycles, alternate grants, no bubbles
        n0 = vi(0, 16'd2);  w0 = vi(0, 16'd5);
        n1 = vi(0, 16'd7);  w1 = vi(0, 16'hFFFD);
        exp_a = pv(0, 32'd10);
        exp_b = pv(0, 32'hFFFF_FFEB);
        bus.req_valid = 2'b11;
        #1;
        check("t2_gnt0", bus.req_ready, 2'b01);
        check("t2_rv0",  bus.res_valid, 1'b0);
        tick();
        #1;
        check("t2_gnt1", bus.req_ready, 2'b10);
        tick();
        #1;
        check("t2_gnt2",  bus.req_ready, 2'b01);
        check("t2_rv2",   bus.res_valid, 1'b1);
        check("t2_id2",   bus.res_id,    1'b0);
        check("t2_data2", bus.res_data,  exp_a);
        tick();
        #1;
        check("t2_gnt3",  bus.req_ready, 2'b10);
        check("t2_id3",   bus.res_id,    1'b1);
        check("t2_data3", bus.res_data,  exp_b);
        tick();
        bus.req_valid = 2'b00;
        #1;
        check("t2_rv4",   bus.res_valid, 1'b1);
        check("t2_id4",   bus.res_id,    1'b0);
        check("t2_data4", bus.res_data,  exp_a);
        tick();
        #1;
        check("t2_rv5",   bus.res_valid, 1'b1);
        check("t2_id5",   bus.res_id,    1'b1);
        check("t2_data5", bus.res_data,  exp_b);
        tick();
        #1;
        check("t2_rv6", bus.res_valid, 1'b0);

        // 4: backpressure for 5 cycles with a stream on req0
        bus.res_ready = 1'b0;
        bus.req_valid = 2'b01;
        n0 = vi(0, 16'd1);
        w0 = vi(0, 16'd100);
        #1;
        check("t4_gnt_d0", bus.req_ready, 2'b01);
        tick();
        n0 = vi(0, 16'd2);
        #1;
        check("t4_gnt_d1", bus.req_ready, 2'b01);
        tick();
        n0 = vi(0, 16'd3);
        #1;
        check("t4_gnt_d2",  bus.req_ready, 2'b00);
        check("t4_rv_d2",   bus.res_valid, 1'b1);
        check("t4_data_d2", bus.res_data,  pv(0, 32'd100));
        tick();
        #1;
        check("t4_gnt_d3",  bus.req_ready, 2'b00);
        check("t4_data_d3", bus.res_data,  pv(0, 32'd100));
        check("t4_id_d3",   bus.res_id,    1'b0);
        tick();
        #1;
        check("t4_gnt_d4",  bus.req_ready, 2'b00);
        check("t4_data_d4", bus.res_data,  pv(0, 32'd100));
        bus.res_ready = 1'b1;
        #1;
        check("t4_gnt_d5",  bus.req_ready, 2'b01);
        check("t4_data_d5", bus.res_data,  pv(0, 32'd100));
        tick();
        bus.req_valid = 2'b00;
        #1;
        check("t4_rv_d6",   bus.res_valid, 1'b1);
        check("t4_data_d6", bus.res_data,  pv(0, 32'd200));
        tick();
        #1;
        check("t4_rv_d7",   bus.res_valid, 1'b1);
        check("t4_data_d7", bus.res_data,  pv(0, 32'd300));
        tick();
        #1;
        check("t4_rv_d8",   bus.res_valid, 1'b0);
        check("t4_busy_d8", busy,          1'b0);

        // 5: clr mid-stream keeps the pointer, then reset mid-stream clears it
        n0 = vi(0, 16'd4);
        w0 = vi(0, 16'd100);
        bus.req_valid = 2'b01;
        #1;
        check("t5_gnt_a", bus.req_ready, 2'b01);
        tick();
        #1;
        check("t5_gnt_b", bus.req_ready, 2'b01);
        tick();
        clr = 1'b1;
        #1;
        check("t5_clr_gnt",  bus.req_ready, 2'b00);
        check("t5_clr_busy", busy,          1'b1);
        tick();
        clr = 1'b0;
        bus.req_valid = 2'b00;
        #1;
        check("t5_clr_busy_after", busy,          1'b0);
        check("t5_clr_rv_after",   bus.res_valid, 1'b0);
        bus.req_valid = 2'b11;
        #1;
        check("t5_ptr_kept", bus.req_ready, 2'b10);
        tick();
        #1;
        check("t5_gnt_wrap", bus.req_ready, 2'b01);
        tick();
        rst_n = 1'b0;
        #1;
        check("t5_rst_gnt", bus.req_ready, 2'b00);
        tick();
        #1;
        check("t5_rst_busy", busy,          1'b0);
        check("t5_rst_rv",   bus.res_valid, 1'b0);
        check("t5_rst_id",   bus.res_id,    1'b0);
        check("t5_rst_data", bus.res_data,  '0);
        check("t5_rst_gnt2", bus.req_ready, 2'b00);
        rst_n = 1'b1;
        #1;
        check("t5_first_gnt", bus.req_ready, 2'b01);
        tick();
        bus.req_valid = 2'b00;
        tick();
        #1;
        check("t5_post_rv",   bus.res_valid, 1'b1);
        check("t5_post_id",   bus.res_id,    1'b0);
        check("t5_post_data", bus.res_data,  pv(0, 32'd400));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
